// File: rtl/force_accumulate_unit.sv
// force_accumulate_unit
//   Per-cell force accumulator. Force packets ejected from the ring are
//   buffered in a small FIFO. A two-stage pipeline then read-modify-writes
//   them into a per-particle force store: S0 reads the store, S1 adds and
//   writes. Motion update reads a slot and clears it in the same operation.
//   The ring side has no backpressure. A packet is taken in every cycle that
//   force_wr_enable is high. A packet that arrives while the FIFO is full is
//   dropped and flagged in err[0]. A read request is accepted in every cycle.
//   Its answer is a single-cycle force_valid_to_mu pulse in the next cycle.
//
// Optional feature macro: FORCE_ACC_SATURATE_EN.
//   When defined, each component add saturates. When undefined, it wraps.
//
// Ports
//   clk                 clock
//   rst                 asynchronous active-low reset
//   force_wr_enable     packet valid from the ring
//   force_and_addr_in   {pid, fz, fy, fx}, with fx in the LSBs
//   mu_rd_request       motion-update read-and-clear request
//   mu_rd_addr          slot to read
//   force_to_mu         {fz, fy, fx} read result (cycle after the request)
//   force_id_to_mu      slot id of the returned data
//   force_valid_to_mu   read result valid pulse
//   input_buffer_empty  registered: FIFO empty and no accumulate in flight
//   err                 sticky: [0] FIFO overflow, [1] out-of-range pid
module force_accumulate_unit #(
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int FORCE_CACHE_DEPTH = 100,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    force_wr_enable,
    input  logic [PARTICLE_ID_WIDTH+3*DATA_WIDTH-1:0] force_and_addr_in,
    input  logic                                    mu_rd_request,
    input  logic [PARTICLE_ID_WIDTH-1:0]            mu_rd_addr,
    output logic [3*DATA_WIDTH-1:0]                 force_to_mu,
    output logic [PARTICLE_ID_WIDTH-1:0]            force_id_to_mu,
    output logic                                    force_valid_to_mu,
    output logic                                    input_buffer_empty,
    output logic [1:0]                              err
);

    localparam int PKT_W = PARTICLE_ID_WIDTH + 3 * DATA_WIDTH;
    localparam int FW    = 3 * DATA_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PARTICLE_ID_WIDTH-1:0] LAST_ID = PARTICLE_ID_WIDTH'(FORCE_CACHE_DEPTH - 1);

    function automatic logic [DATA_WIDTH-1:0] add_comp(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
`ifdef FORCE_ACC_SATURATE_EN
        logic [DATA_WIDTH:0] wide;
        wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        // Sign bits disagree only when the true sum left the representable range.
        if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1])
            return wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return wide[DATA_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // ---------------- input FIFO ----------------
    logic [PKT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;
    logic             fifo_empty, fifo_full, pop, push, overflow;

    logic [PKT_W-1:0]             head;
    logic [PARTICLE_ID_WIDTH-1:0] head_pid;
    logic [FW-1:0]                head_force;
    logic                         head_ok;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    // Motion-update reads take priority: S0 stalls during a request cycle.
    assign pop        = !fifo_empty && !mu_rd_request;
    // A write into a full FIFO is still accepted if the head leaves this cycle.
    assign push       = force_wr_enable && (!fifo_full || pop);
    assign overflow   = force_wr_enable && fifo_full && !pop;
    assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    assign head       = fifo_mem[rd_ptr];
    assign head_pid   = head[PKT_W-1 -: PARTICLE_ID_WIDTH];
    assign head_force = head[FW-1:0];
    assign head_ok    = (head_pid <= LAST_ID);

    // ---------------- force store and pipeline ----------------
    logic [FW-1:0]                store_mem [FORCE_CACHE_DEPTH];
    logic [FORCE_CACHE_DEPTH-1:0] slot_valid;

    // A read issued last cycle clears its slot at the end of this cycle.
    // Reads made this cycle must already treat that slot as empty.
    logic                         mu_q_valid;
    logic [PARTICLE_ID_WIDTH-1:0] mu_q_addr;

    logic                         s1_valid, s1_old_live;
    logic [PARTICLE_ID_WIDTH-1:0] s1_pid;
    logic [FW-1:0]                s1_old, s1_delta, s1_base, s1_sum;

    logic                         lw_valid;
    logic [PARTICLE_ID_WIDTH-1:0] lw_pid;
    logic [FW-1:0]                lw_sum;

    logic                         head_live, mu_live, mu_in_range, s1_valid_next;
    logic [FW-1:0]                mu_value;

    assign head_live     = slot_valid[head_pid] && !(mu_q_valid && mu_q_addr == head_pid);
    assign mu_in_range   = (mu_rd_addr <= LAST_ID);
    assign mu_live       = slot_valid[mu_rd_addr] && !(mu_q_valid && mu_q_addr == mu_rd_addr);
    assign s1_valid_next = pop && head_ok;

    always_comb begin
        s1_base = '0;
        s1_sum  = '0;
        // The store returns old data when it is read and written in the same
        // cycle. A hit on the previous S1 write therefore takes that write's sum.
        if (lw_valid && lw_pid == s1_pid)
            s1_base = lw_sum;
        else if (s1_old_live)
            s1_base = s1_old;
        for (int k = 0; k < 3; k++)
            s1_sum[k*DATA_WIDTH +: DATA_WIDTH] = add_comp(s1_base[k*DATA_WIDTH +: DATA_WIDTH],
                                                          s1_delta[k*DATA_WIDTH +: DATA_WIDTH]);
    end

    // A read includes the S1 write that lands in the same cycle.
    always_comb begin
        mu_value = '0;
        if (s1_valid && s1_pid == mu_rd_addr)
            mu_value = s1_sum;
        else if (mu_in_range && mu_live)
            mu_value = store_mem[mu_rd_addr];
    end

    // Storage that is never reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= force_and_addr_in;
        if (s1_valid)
            store_mem[s1_pid] <= s1_sum;
        if (s1_valid_next) begin
            s1_old   <= store_mem[head_pid];
            s1_delta <= head_force;
        end
        if (s1_valid)
            lw_sum <= s1_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            s1_valid           <= 1'b0;
            s1_old_live        <= 1'b0;
            s1_pid             <= '0;
            lw_valid           <= 1'b0;
            lw_pid             <= '0;
            mu_q_valid         <= 1'b0;
            mu_q_addr          <= '0;
            slot_valid         <= '0;
            force_to_mu        <= '0;
            force_id_to_mu     <= '0;
            force_valid_to_mu  <= 1'b0;
            input_buffer_empty <= 1'b1;
            err                <= 2'b00;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;

            // S0: an out-of-range pid is consumed here and never reaches the store.
            s1_valid <= s1_valid_next;
            if (s1_valid_next) begin
                s1_pid      <= head_pid;
                s1_old_live <= head_live;
            end

            lw_valid <= s1_valid;
            if (s1_valid)
                lw_pid <= s1_pid;

            if (mu_q_valid)
                slot_valid[mu_q_addr] <= 1'b0;
            if (s1_valid)
                slot_valid[s1_pid] <= 1'b1;

            mu_q_valid <= mu_rd_request && mu_in_range;
            mu_q_addr  <= mu_rd_addr;

            force_valid_to_mu <= mu_rd_request;
            if (mu_rd_request) begin
                force_to_mu    <= mu_value;
                force_id_to_mu <= mu_rd_addr;
            end

            input_buffer_empty <= (count_next == '0) && !s1_valid_next;

            if (overflow)
                err[0] <= 1'b1;
            if (pop && !head_ok)
                err[1] <= 1'b1;
        end
    end

endmodule

// File: doc/force_accumulate_unit.md
# force_accumulate_unit

Per-cell force accumulator between the ring interconnect's delivery port and the motion-update read path. It buffers force packets ejected at this cell and read-modify-writes them into a per-particle force store, forwarding across back-to-back hits on the same particle. It serves read-and-clear requests from motion update, and reports when its input path is drained so the top level can gate motion-update start. One instance per cell.

## Interface
- DATA_WIDTH, 32, width of one force component (signed two's complement fixed point)
- PARTICLE_ID_WIDTH, 7, particle index width
- FORCE_CACHE_DEPTH, 100, number of particle slots (legal ids 0..DEPTH-1)
- FIFO_DEPTH, 8, input buffer entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- force_wr_enable  in  1  force packet valid from ring (no backpressure toward ring)
- force_and_addr_in  in  PARTICLE_ID_WIDTH+3*DATA_WIDTH  {pid, fz, fy, fx}, fx in LSBs
- mu_rd_request  in  1  motion-update read-and-clear request
- mu_rd_addr  in  PARTICLE_ID_WIDTH  slot to read
- force_to_mu  out  3*DATA_WIDTH  {fz, fy, fx} read result
- force_id_to_mu  out  PARTICLE_ID_WIDTH  id of returned data
- force_valid_to_mu  out  1  read result valid
- input_buffer_empty  out  1  FIFO empty and no accumulate stage busy
- err  out  2  sticky: [0] FIFO overflow, [1] out-of-range id

## Operation
- Input FIFO pushes on force_wr_enable. A push when full is dropped and sets err[0]. A push and pop in the same cycle while full is accepted.
- Pipeline stage S0 pops the head when the FIFO is not empty and mu_rd_request is low, then presents pid as the store read address.
- Stage S1 takes the store data, adds per component, and asserts the write for the same pid in the same cycle.
- Any pid ≥ FORCE_CACHE_DEPTH is discarded in S0 and sets err[1]. No store access is made for it.
- Per-slot valid bits, one per slot:
  - All valid bits clear on reset.
  - An invalid slot reads as zero.
  - An S1 write sets the slot's valid bit.
  - The store RAM itself is never reset.
- Forwarding: a last-write register holds {valid, pid, sum} from the previous S1.
  - If S1's pid matches it, the register's sum replaces the RAM output, because the store returns old data on read-during-write.
  - A distance-2 hit sees committed data and needs no forwarding.
- MU read:
  - mu_rd_request in cycle c returns data in cycle c+1: valid pulse, id, and value, which is zero if the slot's valid bit is clear.
  - The slot's valid bit clears at the end of cycle c+1.
  - The MU read has priority: S0 does not pop in a request cycle; S1 still completes.
  - If S1 writes the requested slot in cycle c, the returned value includes that write, and the slot is then cleared.
- Per-component add: DATA_WIDTH-bit signed; overflow behaviour per Configuration.
- Reset mid-operation empties the FIFO and the pipeline and clears valid bits. The err bits clear only on reset.

## Timing
- Reset values: force_to_mu=0, force_id_to_mu=0, force_valid_to_mu=0, input_buffer_empty=1, err=0.
- Packet latency with an empty FIFO:
  - A packet arriving in cycle t is in the FIFO at t+1.
  - It is popped in S0 at t+1 and is in S1 at t+2.
  - The write commits at the end of t+2, and an MU request at t+3 observes it.
- Sustained throughput is one packet per cycle, including back-to-back same-pid packets.
- input_buffer_empty is registered. It falls the cycle after a push and rises the cycle after the last S1 completes with the FIFO empty.
- force_valid_to_mu is a single-cycle pulse per request. Requests may be issued every cycle.

## Configuration
- FORCE_ACC_SATURATE_EN defined: each component add saturates.
  - Positive overflow gives 2^(DATA_WIDTH-1)-1.
  - Negative overflow gives -2^(DATA_WIDTH-1).
- FORCE_ACC_SATURATE_EN undefined: plain two's-complement wrap-around.

## Test plan
- Reset, then drive pid=5 with (1,2,3) and later pid=5 with (10,20,30); an MU read of 5 -> returns (11,22,33); a second read of 5 -> returns (0,0,0).
- Drive four consecutive packets to pid=9, each (1,-1,2) -> a read returns (4,-4,8), proving forwarding; input_buffer_empty is 1 by 3 cycles after the last push.
- Fill the FIFO with 9 pushes while mu_rd_request is held high -> err[0]=1; 8 entries are retained and accumulate once the request drops.
- Push pid=100 with DEPTH=100 -> err[1]=1; no slot is changed; a read of 99 returns 0.
- fx=0x7FFFFFFF plus fx=1 on pid=0 -> read gives 0x7FFFFFFF with FORCE_ACC_SATURATE_EN, 0x80000000 without it.
- Assert rst mid-stream with FIFO occupancy 5 -> all outputs return to reset values, and reads of the touched slots return 0.
